sopc_scope_sys_capture_ctrl: RTL and testbench

//  Sequences sample capture into the 8-bit single-port sample RAM (DEPTH bytes, 1-cycle read latency)
//  and shares that RAM with the CPU read path. It stores ADC samples into a circular buffer,

---
 rtl/sopc_scope_sys_capture_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_sopc_scope_sys_capture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_scope_sys_capture_ctrl.sv
// rtl/sopc_scope_sys_capture_ctrl.sv - capture sequencer and CPU read remap for the scope sample RAM
//
// Purpose:
//   Streams ADC samples into a single-port circular sample RAM (DEPTH bytes,
//   1-cycle read latency). It fills the pre-trigger window, evaluates the
//   trigger, fills the post-trigger window and stops. The CPU reads the
//   record by offset from its first sample; this block turns the offset into
//   a physical RAM address and shares the RAM port with the sample writer.
//
// Optional feature macro: DECIMATE_EN
//   When defined, adds input decim[7:0]. Only every (decim+1)-th sample_valid
//   is stored and evaluated. The phase counter clears on start.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   start, abort, force_trig     control pulses
//   trig_level, trig_slope       trigger threshold (unsigned) and edge (0 rising, 1 falling)
//   pretrig                      samples kept before the trigger (clamped to DEPTH-1)
//   sample_valid, sample_data    ADC sample stream
//   busy, done, trig_addr        status; trig_addr is the physical address of the trigger sample
//   cpu_read, cpu_address        CPU read request, offset from record start
//   cpu_waitrequest              combinational stall (sample write owns the RAM)
//   cpu_readdata, cpu_readdatavalid  read response, one cycle after acceptance
//   ram_*                        sample RAM port

module sopc_scope_sys_capture_ctrl #(
  parameter int DEPTH  = 40096,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
`ifdef DECIMATE_EN
  input  logic [7:0]        decim,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_ARMED,
    ST_POSTTRIG,
    ST_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt;        // pre-trigger fill count, then post-trigger fill count
  logic [ADDR_W-1:0] pre_q;      // clamped pretrig latched at start
  logic [DATA_W-1:0] prev;
  logic              have_prev;  // false until the first sample of this capture is stored
  logic              force_pend;
  logic              rd_oob;

  logic              capturing;
  logic              take;
  logic              store;
  logic              level_hit;
  logic              fire;
  logic              rd_issue;
  logic              in_range;
  logic [ADDR_W-1:0] pre_clamp;
  logic [ADDR_W-1:0] post_target;
  logic [ADDR_W:0]   start_addr;
  logic [ADDR_W:0]   phys_sum;
  logic [ADDR_W-1:0] phys;

`ifdef DECIMATE_EN
  logic [7:0] decim_cnt;
  assign take = (decim_cnt == 8'd0);
`else
  assign take = 1'b1;
`endif

  assign capturing = (state == ST_PRETRIG) || (state == ST_ARMED) || (state == ST_POSTTRIG);

  // The sample write is combinational so the sample lands in the cycle it is
  // strobed; abort suppresses it so nothing is written once cancel is seen.
  assign store = reset_n && capturing && sample_valid && take && !abort;

  assign pre_clamp   = (pretrig > LAST) ? LAST : pretrig;
  assign post_target = LAST - pre_q;

  assign level_hit = have_prev &&
                     (trig_slope ? ((prev > trig_level) && (sample_data <= trig_level))
                                 : ((prev < trig_level) && (sample_data >= trig_level)));
  assign fire = (state == ST_ARMED) && store && (force_pend || force_trig || level_hit);

  // Record start = trig_addr - pre_q modulo DEPTH; DEPTH is added before the
  // subtraction when it would go negative, since DEPTH is not a power of two.
  always_comb begin
    start_addr = '0;
    if (trig_addr >= pre_q) begin
      start_addr = {1'b0, trig_addr - pre_q};
    end else begin
      start_addr = {1'b0, trig_addr} + DEPTH_X - {1'b0, pre_q};
    end
  end

  assign phys_sum = start_addr + {1'b0, cpu_address};
  assign phys     = ADDR_W'((phys_sum >= DEPTH_X) ? (phys_sum - DEPTH_X) : phys_sum);
  assign in_range = ({1'b0, cpu_address} < DEPTH_X);

  assign cpu_waitrequest = cpu_read && store;
  assign rd_issue        = reset_n && cpu_read && !store;

  assign ram_write      = store;
  assign ram_chipselect = store || (rd_issue && in_range);
  assign ram_address    = store ? wr_ptr : phys;
  assign ram_writedata  = sample_data;

  assign cpu_readdata = rd_oob ? '0 : ram_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      trig_addr         <= '0;
      wr_ptr            <= '0;
      cnt               <= '0;
      pre_q             <= '0;
      prev              <= '0;
      have_prev         <= 1'b0;
      force_pend        <= 1'b0;
      cpu_readdatavalid <= 1'b0;
      rd_oob            <= 1'b0;
`ifdef DECIMATE_EN
      decim_cnt         <= '0;
`endif
    end else begin
      cpu_readdatavalid <= rd_issue;
      rd_oob            <= !in_range;

      if (abort) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        done       <= 1'b0;
        force_pend <= 1'b0;
      end else if (start && !capturing) begin
        pre_q      <= pre_clamp;
        wr_ptr     <= '0;
        cnt        <= '0;
        have_prev  <= 1'b0;
        force_pend <= 1'b0;
        busy       <= 1'b1;
        done       <= 1'b0;
        state      <= (pre_clamp == '0) ? ST_ARMED : ST_PRETRIG;
`ifdef DECIMATE_EN
        decim_cnt  <= '0;
`endif
      end else begin
`ifdef DECIMATE_EN
        if (capturing && sample_valid) begin
          decim_cnt <= (decim_cnt >= decim) ? 8'd0 : decim_cnt + 8'd1;
        end
`endif
        if ((state == ST_ARMED) && force_trig) begin
          force_pend <= 1'b1;
        end

        if (store) begin
          wr_ptr    <= (wr_ptr == LAST) ? '0 : wr_ptr + ONE;
          prev      <= sample_data;
          have_prev <= 1'b1;

          case (state)
            ST_PRETRIG: begin
              if (cnt == pre_q - ONE) begin
                cnt   <= '0;
                state <= ST_ARMED;
              end else begin
                cnt <= cnt + ONE;
              end
            end
            ST_ARMED: begin
              if (fire) begin
                trig_addr  <= wr_ptr;
                force_pend <= 1'b0;
                // The trigger sample is the first of the post-trigger fill.
                if (post_target <= ONE) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  cnt   <= ONE;
                  state <= ST_POSTTRIG;
                end
              end
            end
            ST_POSTTRIG: begin
              if (cnt + ONE >= post_target) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                cnt <= cnt + ONE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sopc_scope_sys_capture_ctrl.sv
// tb/tb_sopc_scope_sys_capture_ctrl.sv - scoreboard bench for the scope capture controller
module tb_sopc_scope_sys_capture_ctrl;
  localparam int DEPTH = 40096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, force_trig = 1'b0, trig_slope = 1'b0;
  logic [7:0]  trig_level = 8'h00, sample_data = 8'h00;
  logic [15:0] pretrig = 16'h0000, cpu_address = 16'h0000;
  logic        sample_valid = 1'b0, cpu_read = 1'b0;
`ifdef DECIMATE_EN
  logic [7:0]  decim = 8'h00;
`endif
  logic        busy, done, cpu_waitrequest, cpu_readdatavalid;
  logic [15:0] trig_addr, ram_address;
  logic [7:0]  cpu_readdata, ram_writedata;
  logic        ram_chipselect, ram_write;
  logic [7:0]  ram_readdata = 8'h00;

  sopc_scope_sys_capture_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .force_trig(force_trig),
    .trig_level(trig_level), .trig_slope(trig_slope), .pretrig(pretrig),
    .sample_valid(sample_valid), .sample_data(sample_data),
`ifdef DECIMATE_EN
    .decim(decim),
`endif
    .busy(busy), .done(done), .trig_addr(trig_addr),
    .cpu_read(cpu_read), .cpu_address(cpu_address), .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  // Sample RAM the controller drives
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_chipselect && ram_write) ram[ram_address] <= ram_writedata;
    if (ram_chipselect && !ram_write) ram_readdata <= ram[ram_address];
  end

  // Reference model: expected RAM image and capture bookkeeping
  logic [7:0] ref_mem [DEPTH];
  bit  m_active, m_done, m_trig, m_fpend;
  int  m_n, m_pre, m_post, m_trig_addr, m_prev, m_phase, m_dec;

  logic [23:0] wq[$];
  logic [7:0]  rq[$];
  bit exp_wait, exp_store, exp_busy, exp_done, exp_rvalid, last_acc;
  int exp_trig;
  bit mon_en = 1'b0;
  int n_tests = 0, n_fail = 0, n_beats = 0, n_writes = 0;
  logic [7:0] last_rdata;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int map_off(input int k);
    return ((m_trig_addr - m_pre + DEPTH) % DEPTH + k) % DEPTH;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     <= 8'((i * 7 + 3) & 255);
      ref_mem[i]  = 8'((i * 7 + 3) & 255);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("waitrequest", cpu_waitrequest, exp_wait);
      chk("ram_write", ram_write, exp_store);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("trig_addr", trig_addr, exp_trig);
      chk("readdatavalid", cpu_readdatavalid, exp_rvalid);
      if (ram_write) begin
        n_writes++;
        if (wq.size() == 0) chk("unexpected write", {ram_address, ram_writedata}, 0);
        else chk("write addr/data", {ram_address, ram_writedata}, wq.pop_front());
      end
      if (cpu_readdatavalid) begin
        n_beats++;
        last_rdata = cpu_readdata;
        if (rq.size() == 0) chk("unexpected read beat", cpu_readdata, 8'hxx);
        else chk("readdata", cpu_readdata, rq.pop_front());
      end
    end
  end

  task automatic step(input bit st, input bit ab, input bit ft, input bit sv,
                      input logic [7:0] sd, input bit rd, input logic [15:0] ad);
    bit stor, armed, hit;
    int a;
    @(posedge clk); #1;
    start = st; abort = ab; force_trig = ft; sample_valid = sv;
    sample_data = sd; cpu_read = rd; cpu_address = ad;
    exp_busy = m_active; exp_done = m_done; exp_trig = m_trig_addr;
    exp_rvalid = last_acc;
    stor = m_active && sv && !ab && (m_phase == 0);
    exp_store = stor;
    exp_wait = rd && stor;
    last_acc = rd && !stor;
    if (stor) wq.push_back({16'(m_n % DEPTH), sd});
    if (rd && !stor) rq.push_back((int'(ad) >= DEPTH) ? 8'h00 : ref_mem[map_off(int'(ad))]);
    if (ab) begin
      m_active = 0; m_done = 0; m_fpend = 0;
    end else if (st && !m_active) begin
      m_active = 1; m_done = 0; m_n = 0; m_trig = 0; m_fpend = 0; m_phase = 0;
      m_pre = (int'(pretrig) > DEPTH - 1) ? DEPTH - 1 : int'(pretrig);
    end else if (m_active) begin
      if (sv) m_phase = (m_phase >= m_dec) ? 0 : m_phase + 1;
      armed = !m_trig && (m_n >= m_pre);
      if (ft && armed) m_fpend = 1;
      if (stor) begin
        a = m_n % DEPTH;
        ref_mem[a] = sd;
        if (armed) begin
          hit = m_fpend || ((m_n > 0) && (trig_slope ?
                (m_prev > int'(trig_level) && int'(sd) <= int'(trig_level)) :
                (m_prev < int'(trig_level) && int'(sd) >= int'(trig_level))));
          if (hit) begin m_trig = 1; m_trig_addr = a; m_post = 1; m_fpend = 0; end
        end else if (m_trig) begin
          m_post++;
        end
        if (m_trig && m_post >= DEPTH - 1 - m_pre) begin m_active = 0; m_done = 1; end
        m_prev = int'(sd);
        m_n++;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 8'h00, 0, 16'h0000);
  endtask

  task automatic rd_at(input int k);
    step(0, 0, 0, 0, 8'h00, 1, 16'(k));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    mon_en = 0; reset_n = 0;
    start = 0; abort = 0; force_trig = 0; sample_valid = 0; cpu_read = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset trig_addr", trig_addr, 0);
    chk("reset readdatavalid", cpu_readdatavalid, 0);
    chk("reset ram_write", ram_write, 0);
    chk("reset ram_chipselect", ram_chipselect, 0);
    m_active = 0; m_done = 0; m_trig = 0; m_fpend = 0; m_trig_addr = 0; m_pre = 0;
    m_n = 0; m_phase = 0; m_dec = 0;
    exp_wait = 0; exp_store = 0; exp_busy = 0; exp_done = 0; exp_trig = 0;
    exp_rvalid = 0; last_acc = 0;
    @(posedge clk); #1;
    reset_n = 1; mon_en = 1;
  endtask

  initial begin
    logic [7:0] first_s, ramp;
    int b0, w0, cyc, issued;
    bit s;

    do_reset();

    // Samples in IDLE are not written; out-of-range offset reads as zero
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'($urandom), 0, 16'h0);
    rd_at(DEPTH); idle(); idle();
    chk("oob read data", last_rdata, 8'h00);

    // pretrig=0, force while armed: next stored sample is the trigger
    pretrig = 16'd0; trig_slope = 0; trig_level = 8'hFF;
    step(1, 0, 0, 0, 8'h00, 0, 16'h0);
    idle(); idle();
    step(0, 0, 1, 0, 8'h00, 0, 16'h0);
    idle();
    first_s = 8'($urandom_range(0, 254));
    step(0, 0, 0, 1, first_s, 0, 16'h0);
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 254)),
           $urandom_range(0, 2) == 0, 16'($urandom_range(0, 40)));
    idle();
    chk("force trig_addr", trig_addr, 0);
    chk("force busy", busy, 1);
    // abort together with start while in POSTTRIG: abort wins, nothing more is written
    step(1, 1, 0, 0, 8'h00, 0, 16'h0);
    w0 = n_writes;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'($urandom), 0, 16'h0);
    idle();
    chk("writes after abort", n_writes - w0, 0);
    chk("abort done", done, 0);
    rd_at(0); idle(); idle();
    chk("offset 0 is trigger sample", last_rdata, first_s);
    rd_at(40096); idle(); idle();
    chk("read 40096", last_rdata, 8'h00);

    // Five reads with sample writes on window cycles 2 and 4
    pretrig = 16'($urandom_range(5, 20)); trig_slope = $urandom_range(0, 1) == 1;
    trig_level = 8'($urandom);
    step(1, 0, 0, 0, 8'h00, 0, 16'h0);
    b0 = n_beats; cyc = 0; issued = 0;
    while (issued < 5 && cyc < 20) begin
      cyc++;
      s = (cyc == 2) || (cyc == 4);
      step(0, 0, 0, s, 8'($urandom), 1, 16'(issued));
      if (!s) issued++;
    end
    idle(); idle();
    chk("read beats", n_beats - b0, 5);
    // start while busy is ignored (write pointer keeps advancing)
    step(1, 0, 0, 1, 8'($urandom), 0, 16'h0);
    for (int i = 0; i < 60; i++)
      step(0, 0, 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 3) == 0, 16'($urandom_range(0, DEPTH + 5)));
    idle();

    // Reset in the middle of a capture
    do_reset();
    idle();

    // Oversized pretrig clamps to DEPTH-1 in the offset mapping
    pretrig = 16'hFFFF;
    step(1, 0, 0, 0, 8'h00, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'($urandom), 0, 16'h0);
    step(0, 1, 0, 0, 8'h00, 0, 16'h0);
    for (int i = 0; i < 8; i++) rd_at($urandom_range(0, DEPTH - 1));
    rd_at(0); rd_at(1); rd_at(DEPTH - 1);
    idle(); idle();

`ifdef DECIMATE_EN
    decim = 8'd3; m_dec = 3; pretrig = 16'd1000;
    step(1, 0, 0, 0, 8'h00, 0, 16'h0);
    w0 = n_writes;
    for (int i = 0; i < 400; i++) step(0, 0, 0, 1, 8'(i), 0, 16'h0);
    idle();
    chk("decimated writes", n_writes - w0, 100);
    step(0, 1, 0, 0, 8'h00, 0, 16'h0);
    decim = 8'd0; m_dec = 0;
    idle();
`endif

    // Full capture running past the wrap: pretrig=40000, rising on 0x80 ramp
    pretrig = 16'd40000; trig_slope = 0; trig_level = 8'h80;
    step(1, 0, 0, 0, 8'h00, 0, 16'h0);
    ramp = 8'h00; cyc = 0;
    while (!m_done && cyc < 70000) begin
      cyc++;
      s = $urandom_range(0, 9) < 8;
      step(0, 0, 0, s, ramp, $urandom_range(0, 7) == 0, 16'($urandom_range(0, DEPTH + 20)));
      if (s) ramp++;
    end
    chk("capture completed in budget", m_done, 1);
    idle(); idle();
    chk("final done", done, 1);
    chk("final trig_addr", trig_addr, 40064);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'($urandom), 0, 16'h0);
    rd_at(40000); idle(); idle();
    chk("offset pretrig reads 0x80", last_rdata, 8'h80);
    rd_at(0); rd_at(1); rd_at(DEPTH - 2); rd_at(DEPTH - 1); rd_at(DEPTH); rd_at(65535);
    for (int i = 0; i < 200; i++) rd_at($urandom_range(0, DEPTH - 1));
    idle();
    // start from DONE clears done and restarts
    step(1, 0, 0, 0, 8'h00, 0, 16'h0);
    idle(); idle();
    chk("restart busy", busy, 1);
    step(0, 1, 0, 0, 8'h00, 0, 16'h0);
    idle(); idle();

    @(negedge clk);
    mon_en = 0;
    chk("write queue drained", wq.size(), 0);
    chk("read queue drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
